seg_scan_controller: RTL and testbench

Time-multiplexing scheduler for the 8-digit common-anode seven-segment display. It owns the single shared `segment_decoder` and presents one digit's nibble, decimal point and sign flag to it at a time. It drives the active-low anode enables in a fixed round-robin with a blanking gap between digits to suppress ghosting. Display data is double-buffered and swapped only at frame boundaries, so a new value never tears mid-frame.

---
 rtl/seg_scan_controller.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Round-robin scan scheduler for an 8-digit common-anode seven-segment display.
// Presents one digit at a time to the shared segment decoder and drives the
// active-low anodes. Each digit gets a lit dwell slot followed by an all-off gap.
// Display data is double-buffered: loads land in a pending buffer, and the active
// buffer takes the pending contents only at the frame boundary.
// Optional feature macro: SEG_LZ_SUPPRESS_EN (leading-zero suppression).
module seg_scan_controller #(
    parameter int DWELL_CYCLES = 100000,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic        neg_in,
    input  logic        load,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        negative,
    output logic [7:0]  an,
    output logic        frame_done
);

    // The slot counter must hold the larger of the two slot lengths.
    localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    // One complete set of display data for a frame.
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        neg;
    } disp_buf_t;

    // Buffers start fully blanked so the display stays dark until the first load.
    localparam disp_buf_t BUF_RESET = '{value: 32'h0, dp: 8'h00, blank: 8'hFF, neg: 1'b0};

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;

    disp_buf_t       pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    disp_buf_t       act_q, act_d;

    logic [7:0]      an_q, an_d;
    logic [3:0]      digit_q, digit_d;
    logic            dp_q, dp_d;
    logic            neg_q, neg_d;
    logic            frame_done_q, frame_done_d;

    logic [7:0]      dark_mask;
    logic            frame_boundary;

    // The boundary is the end of digit 7's lit slot.
    assign frame_boundary = (state_q == ST_ON) && (cnt_q == DWELL_LAST) && (idx_q == 3'd7);

    // Work out which digits of the active buffer stay dark during their slot.
`ifdef SEG_LZ_SUPPRESS_EN
    always_comb begin
        logic zero_run;
        dark_mask = act_q.blank;
        zero_run  = 1'b1;
        for (int i = 6; i >= 1; i--) begin
            zero_run = zero_run && (act_q.value[i*4 +: 4] == 4'h0);
            if (zero_run && !act_q.dp[i]) begin
                dark_mask[i] = 1'b1;
            end
        end
        if ((act_q.value[31:28] == 4'h0) && !act_q.dp[7] && !act_q.neg) begin
            dark_mask[7] = 1'b1;
        end
    end
`else
    always_comb begin
        dark_mask = act_q.blank;
    end
`endif

    // Pending buffer takes every load; active buffer swaps only at the frame boundary,
    // using the pending contents from before any load in that same cycle.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        if (frame_boundary && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_d.value = value;
            pend_d.dp    = dp_mask;
            pend_d.blank = blank_mask;
            pend_d.neg   = neg_in;
            pend_valid_d = 1'b1;
        end
    end

    // Scan sequencer: alternate gap and lit slots, stepping the digit index after each lit slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        an_d         = an_q;
        digit_d      = digit_q;
        dp_d         = dp_q;
        neg_d        = neg_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    an_d    = dark_mask[idx_q] ? 8'hFF : ~(8'b0000_0001 << idx_q);
                    digit_d = act_q.value[{idx_q, 2'b00} +: 4];
                    dp_d    = act_q.dp[idx_q];
                    neg_d   = (idx_q == 3'd7) && act_q.neg;
                end
            end
            ST_ON: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                    an_d         = 8'hFF;
                    idx_d        = idx_q + 3'd1;
                    neg_d        = 1'b0;
                    frame_done_d = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
                an_d    = 8'hFF;
            end
        endcase
    end

    // State and output registers; reset darkens the display and discards any pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            pend_q       <= BUF_RESET;
            pend_valid_q <= 1'b0;
            act_q        <= BUF_RESET;
            an_q         <= 8'hFF;
            digit_q      <= 4'h0;
            dp_q         <= 1'b0;
            neg_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            act_q        <= act_d;
            an_q         <= an_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            neg_q        <= neg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign digit      = digit_q;
    assign dp         = dp_q;
    assign negative   = neg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller
// Scoreboard bench: a frame-position reference model pushes the expected outputs for
// every clock edge, and a monitor pops and compares them half a cycle later.
module tb_seg_scan_controller;

    localparam int DWELL = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = DWELL + GAP;
    localparam int FRAME = 8 * SLOT;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic        neg_in;
    logic        load;
    logic [3:0]  digit;
    logic        dp;
    logic        negative;
    logic [7:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_controller #(
        .DWELL_CYCLES(DWELL),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_mask   (dp_mask),
        .blank_mask(blank_mask),
        .neg_in    (neg_in),
        .load      (load),
        .digit     (digit),
        .dp        (dp),
        .negative  (negative),
        .an        (an),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        neg;
    } buf_t;

    typedef struct {
        logic       on;
        logic [7:0] an;
        logic [3:0] digit;
        logic       dp;
        logic       neg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int   m_t = 0;
    buf_t m_act;
    buf_t m_pend;
    logic m_pv = 1'b0;
    exp_t m_exp;

    function automatic logic [3:0] nib(buf_t b, int j);
        return 4'((b.value >> (4 * j)) & 32'hF);
    endfunction

    function automatic logic is_dark(buf_t b, int s);
        if (b.blank[s]) return 1'b1;
`ifdef SEG_LZ_SUPPRESS_EN
        if (s == 0) return 1'b0;
        if (s == 7) return (nib(b, 7) == 4'h0) && !b.dp[7] && !b.neg;
        for (int j = s; j <= 6; j++) begin
            if (nib(b, j) != 4'h0) return 1'b0;
        end
        return !b.dp[s];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_act  = '{value: 32'h0, dp: 8'h00, blank: 8'hFF, neg: 1'b0};
        m_pend = '{value: 32'h0, dp: 8'h00, blank: 8'hFF, neg: 1'b0};
        m_pv   = 1'b0;
        exp_q.delete();
    endtask

    // Reference model: the frame position follows from the edge count since reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                int p;
                int s;
                logic boundary;
                m_t++;
                boundary = (m_t % FRAME) == 0;
                if (boundary && m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end
                if (load) begin
                    m_pend = '{value: value, dp: dp_mask, blank: blank_mask, neg: neg_in};
                    m_pv   = 1'b1;
                end
                p = m_t % FRAME;
                s = p / SLOT;
                m_exp.on    = (p % SLOT) >= GAP;
                m_exp.an    = (m_exp.on && !is_dark(m_act, s)) ? ~(8'h01 << s) : 8'hFF;
                m_exp.digit = nib(m_act, s);
                m_exp.dp    = m_act.dp[s];
                m_exp.neg   = m_exp.on && (s == 7) && m_act.neg;
                m_exp.fd    = boundary;
                exp_q.push_back(m_exp);
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("an", 32'(an), 32'(e.an));
                checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
                checkOutput("negative", 32'(negative), 32'(e.neg));
                if (e.on) begin
                    checkOutput("digit", 32'(digit), 32'(e.digit));
                    checkOutput("dp", 32'(dp), 32'(e.dp));
                end
            end
        end
    end

    // Called at a falling edge: present one load strobe, then scramble the data inputs.
    task automatic applyStimulus(logic [31:0] v, logic [7:0] dpm, logic [7:0] blk, logic ng);
        value      = v;
        dp_mask    = dpm;
        blank_mask = blk;
        neg_in     = ng;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
        value      = $urandom;
        dp_mask    = 8'($urandom);
        blank_mask = 8'($urandom);
        neg_in     = 1'($urandom);
    endtask

    task automatic runCycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait until the frame position after the next edge equals target.
    task automatic waitNextPhase(int target, string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (((m_t + 1) % FRAME) == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s: phase %0d not reached, got t=%0d", name, target, m_t);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        load       = 1'b0;
        value      = 32'h0;
        dp_mask    = 8'h00;
        blank_mask = 8'h00;
        neg_in     = 1'b0;
        #1 rst_n   = 1'b0;
        #2;
        checkOutput("reset_an", 32'(an), 32'hFF);
        checkOutput("reset_digit", 32'(digit), 32'h0);
        checkOutput("reset_dp", 32'(dp), 32'h0);
        checkOutput("reset_negative", 32'(negative), 32'h0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] idle frames with no load");
        runCycles(3 * FRAME);

        $display("[TB] single load with decimal point on digit 2");
        runCycles(7);
        applyStimulus(32'h1234ABCD, 8'h04, 8'h00, 1'b0);
        runCycles(2 * FRAME);

        $display("[TB] two loads in one frame, last one wins");
        waitNextPhase(5, "wait_double_load");
        applyStimulus(32'h11111111, 8'h00, 8'h00, 1'b0);
        runCycles(10);
        applyStimulus(32'h22222222, 8'h00, 8'h00, 1'b0);
        runCycles(2 * FRAME);

        $display("[TB] load on the exact boundary cycle");
        waitNextPhase(12, "wait_pre_boundary_load");
        applyStimulus(32'hA5A5_5A5A, 8'h81, 8'h00, 1'b0);
        waitNextPhase(0, "wait_boundary_load");
        applyStimulus(32'h0F0F_F0F0, 8'h10, 8'h02, 1'b0);
        runCycles(3 * FRAME);

        $display("[TB] negative sign with small value");
        applyStimulus(32'h00000005, 8'h00, 8'h00, 1'b1);
        runCycles(2 * FRAME);

        $display("[TB] randomized loads");
        for (int i = 0; i < 24; i++) begin
            runCycles($urandom_range(1, 70));
            applyStimulus($urandom, 8'($urandom), 8'($urandom & $urandom), 1'($urandom));
        end
        runCycles(2 * FRAME);

        $display("[TB] reset during digit 3 lit slot");
        applyStimulus(32'h87654321, 8'h00, 8'h00, 1'b0);
        runCycles(FRAME);
        waitNextPhase(22, "wait_digit3_on");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_an", 32'(an), 32'hFF);
        checkOutput("async_reset_digit", 32'(digit), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runCycles(2 * FRAME);

        $display("[TB] load after reset release");
        applyStimulus(32'hC0FFEE42, 8'h20, 8'h08, 1'b1);
        runCycles(2 * FRAME + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
